// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared types and width helpers for the switch debouncer
package debounce_pkg;

    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} db_state_t;

    localparam int unsigned N_CH_DEF     = 4;
    localparam int unsigned TICK_M_DEF   = 100000;
    localparam int unsigned N_STABLE_DEF = 4;

    // Counter width for a range of n values; never narrower than one bit.
    function automatic int unsigned width_of(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/debounce_ctrl_if.sv
// rtl/debounce_ctrl_if.sv - raw switch inputs and debounced outputs of debounce_ctrl
interface debounce_ctrl_if
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH = N_CH_DEF
);
    logic            en;
    logic [N_CH-1:0] sw;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] db_rise;
    logic [N_CH-1:0] db_fall;
    logic            sample_tick;

    modport master (output en, sw, input db_level, db_rise, db_fall, sample_tick);
    modport slave  (input en, sw, output db_level, db_rise, db_fall, sample_tick);
endinterface

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, qualification FSM and edge pulses for one switch
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned N_STABLE = N_STABLE_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic sw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int unsigned   CW       = width_of(N_STABLE + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N_STABLE);

    logic [1:0]    sync_q;
    logic          sw_s;
    db_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          level_q, rise_q, fall_q;

    assign sw_s    = sync_q[1];
    assign cnt_inc = cnt_q + 1'b1;

    // A reversal is tested before the tick so it always wins over a coincident tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ZERO: if (sw_s) begin
                state_d = WAIT1;
                cnt_d   = '0;
            end
            WAIT1: if (!sw_s) begin
                state_d = ZERO;
                cnt_d   = '0;
            end else if (tick_i) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_LAST) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end
            end
            ONE: if (!sw_s) begin
                state_d = WAIT0;
                cnt_d   = '0;
            end
            WAIT0: if (sw_s) begin
                state_d = ONE;
                cnt_d   = '0;
            end else if (tick_i) begin
                cnt_d = cnt_inc;
                if (cnt_inc == CNT_LAST) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], sw_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= (state_d == ONE) || (state_d == WAIT0);
            rise_q  <= (state_q == WAIT1) && (state_d == ONE);
            fall_q  <= (state_q == WAIT0) && (state_d == ZERO);
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/debounce_ctrl.sv
// rtl/debounce_ctrl.sv - multi-channel debouncer sharing one sample-tick prescaler
module debounce_ctrl
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned TICK_M   = TICK_M_DEF,
    parameter int unsigned N_STABLE = N_STABLE_DEF
) (
    input  logic            clk,
    input  logic            reset,
    debounce_ctrl_if.slave  bus
);
    localparam int unsigned   PW     = width_of(TICK_M);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_M - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic [N_CH-1:0] level_w, rise_w, fall_w;

    assign tick = bus.en && (presc_q == P_LAST);

    always_comb begin
        presc_d = presc_q;
        if (bus.en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .N_STABLE (N_STABLE)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .tick_i  (tick),
            .sw_i    (bus.sw[g]),
            .level_o (level_w[g]),
            .rise_o  (rise_w[g]),
            .fall_o  (fall_w[g])
        );
    end

    assign bus.db_level    = level_w;
    assign bus.db_rise     = rise_w;
    assign bus.db_fall     = fall_w;
    assign bus.sample_tick = tick;

endmodule
